// File: rtl/register_file_scoreboard.sv
// Integer register file with write-through bypass and a per-register
// pending-write scoreboard that stalls decode on RAW hazards and counter saturation.

module register_file_scoreboard_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             ret,
  output logic [CNT_W-1:0] cnt,
  output logic             under
);
  // A retire against an empty counter is an accounting error, not a decrement.
  assign under = ret && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n)                          cnt <= '0;
    else if (inc && !ret)                cnt <= cnt + 1'b1;
    else if (ret && !inc && cnt != '0)   cnt <= cnt - 1'b1;
  end
endmodule

module register_file_scoreboard #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic            use_rs1_d,
  input  logic            use_rs2_d,
  input  logic            issue_valid_d,
  input  logic            issue_writes_d,
  input  logic [4:0]      issue_rd_d,
  output logic [XLEN-1:0] rd1_d,
  output logic [XLEN-1:0] rd2_d,
  output logic            stall_d,
  output logic            sb_error
);
  logic [NREG-1:0][XLEN-1:0]  regs;
  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            ret, inc, under;
  logic                       accept, sat;

  always_ff @(posedge clk) begin
    if (!rst_n)                          regs <= '0;
    else if (reg_write_w && rd_w != '0)  regs[rd_w] <= result_w;
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] rs);
    if (rs == '0)                          return '0;
    else if (reg_write_w && rd_w == rs)    return result_w;
    else                                   return regs[rs];
  endfunction

  // A retire this cycle credits one pending write; the bypass supplies its value.
  function automatic logic hazard(input logic [4:0] r);
    logic [CNT_W-1:0] eff;
    eff = cnt[r] - CNT_W'(ret[r] && cnt[r] != '0);
    return (r != '0) && (eff != '0);
  endfunction

  assign rd1_d = rd_port(rs1_d);
  assign rd2_d = rd_port(rs2_d);

  assign sat     = issue_writes_d && issue_rd_d != '0 && cnt[issue_rd_d] == {CNT_W{1'b1}};
  assign stall_d = issue_valid_d &&
                   ((use_rs1_d && hazard(rs1_d)) || (use_rs2_d && hazard(rs2_d)) || sat);
  assign accept  = issue_valid_d && !stall_d && issue_writes_d;

  genvar r;
  generate
    for (r = 0; r < NREG; r++) begin : g_sb
      if (r == 0) begin : g_x0
        assign cnt[r]   = '0;
        assign ret[r]   = 1'b0;
        assign inc[r]   = 1'b0;
        assign under[r] = 1'b0;
      end else begin : g_xn
        assign ret[r] = reg_write_w && rd_w == 5'(r);
        assign inc[r] = accept && issue_rd_d == 5'(r);
        register_file_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
          .clk   (clk),
          .rst_n (rst_n),
          .inc   (inc[r]),
          .ret   (ret[r]),
          .cnt   (cnt[r]),
          .under (under[r])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n)       sb_error <= 1'b0;
    else if (|under)  sb_error <= 1'b1;
  end
endmodule
